// File: rtl/imem_loader.sv
// ============================================================================
//  Module      : imem_loader
//  Description : Instruction-memory writer. Takes a length-prefixed byte
//                stream over valid/ready, packs bytes big-endian into 32-bit
//                words and writes them sequentially, holding the CPU frozen
//                while a load session is active.
//                Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing
//                XOR checksum byte after the data).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int          MAX_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHK    = 3'd5;
`endif

  logic [2:0]  state;
  logic [2:0]  state_nx;
  logic [15:0] count;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;
  logic        accept;
  logic [16:0] hdr_count;
  logic        hdr_zero;
  logic        hdr_too_big;
  logic        last_word;
  logic        start_ok;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign accept      = in_valid & in_ready;
  // Full header value as seen on the edge that accepts the low length byte.
  assign hdr_count   = {1'b0, count[15:8], in_data};
  assign hdr_zero    = (hdr_count == 17'd0);
  assign hdr_too_big = (hdr_count > 17'(MAX_WORDS));
  // True while the word currently being assembled is the final one.
  assign last_word   = (({1'b0, words_loaded} + 17'd1) == {1'b0, count});
  assign start_ok    = start & ((state == S_IDLE) | (state == S_DONE));

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_LEN_HI;
      S_LEN_HI: if (accept) state_nx = S_LEN_LO;
      S_LEN_LO: begin
        if (accept) begin
          if (hdr_zero || hdr_too_big) state_nx = S_DONE;
          else                         state_nx = S_DATA;
        end
      end
      S_DATA: begin
        if (accept && (byte_idx == 2'd3) && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nx = S_CHK;
`else
          state_nx = S_DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK:    if (accept) state_nx = S_DONE;
`endif
      S_DONE:   if (start) state_nx = S_LEN_HI;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state)
      S_LEN_HI, S_LEN_LO, S_DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
`endif
      S_IDLE, S_DONE: begin
        in_ready = 1'b0;
        busy     = 1'b0;
      end
      default: begin
        in_ready = 1'b0;
        busy     = 1'b1;
      end
    endcase
    cpu_hold = busy;
  end

  // Datapath: header capture, word packing, write strobe and status flags
  always_ff @(posedge clock) begin
    if (reset) begin
      count        <= 16'd0;
      byte_idx     <= 2'd0;
      word_buf     <= 24'd0;
      mem_we       <= 1'b0;
      mem_addr     <= BASE_ADDR;
      mem_wdata    <= 32'd0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum         <= 8'd0;
`endif
    end else begin
      // Write strobe is a single-cycle pulse.
      mem_we <= 1'b0;

      if (start_ok) begin
        done         <= 1'b0;
        error        <= 1'b0;
        words_loaded <= 16'd0;
        byte_idx     <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum         <= 8'd0;
`endif
      end

      if (accept) begin
        case (state)
          S_LEN_HI: count[15:8] <= in_data;
          S_LEN_LO: begin
            count[7:0] <= in_data;
            if (hdr_zero) begin
              done <= 1'b1;
            end else if (hdr_too_big) begin
              done  <= 1'b1;
              error <= 1'b1;
            end
          end
          S_DATA: begin
            byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= csum ^ in_data;
`endif
            case (byte_idx)
              2'd0: word_buf[23:16] <= in_data;
              2'd1: word_buf[15:8]  <= in_data;
              2'd2: word_buf[7:0]   <= in_data;
              default: begin
                mem_wdata    <= {word_buf, in_data};
                mem_addr     <= BASE_ADDR + {14'd0, words_loaded, 2'b00};
                mem_we       <= 1'b1;
                words_loaded <= words_loaded + 16'd1;
`ifndef IMEM_LOADER_CHECKSUM_EN
                if (last_word) done <= 1'b1;
`endif
              end
            endcase
          end
`ifdef IMEM_LOADER_CHECKSUM_EN
          S_CHK: begin
            done  <= 1'b1;
            error <= (in_data != csum);
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader. Sessions are driven with
//                directed and $urandom stimulus; expected memory writes are
//                queued by a word-level model and popped by a write monitor.
//                Honours IMEM_LOADER_CHECKSUM_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

  localparam int          MAXW = 256;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_q[$];   // {addr, data} of each write the model predicts
  logic [31:0] words[$];   // directed payload words; random when empty

  imem_loader #(
    .MAX_WORDS (MAXW),
    .BASE_ADDR (BASE)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest predicted write.
  always @(negedge clock) begin
    logic [63:0] e;
    if (!reset && mem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", mem_addr, e[63:32]);
        check("wr_data", mem_wdata, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer one byte after 'gap' idle cycles; returns just after it is taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int  guard;
    bit  acc;
    repeat (gap) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom());
      tick();
    end
    in_data  = b;
    in_valid = 1'b1;
    guard    = 0;
    acc      = 1'b0;
    while (!acc) begin
      acc = in_ready;
      tick();
      guard++;
      if (!acc && guard > 100) begin
        checks++;
        errors++;
        $display("FAIL byte_timeout: got in_ready=0 for 100 cycles expected acceptance");
        acc = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_session(input logic [15:0] cnt, input int gap, input bit rand_gap,
                             input bit start_glitch, input bit bad_csum);
    logic [7:0]  x;
    logic [31:0] w;
    logic [7:0]  b;
    bit          exp_err;
    int          g;
    x       = 8'd0;
    exp_err = 1'b0;
    pulse_start();
    check("busy_after_start", 32'(busy), 32'd1);
    check("hold_after_start", 32'(cpu_hold), 32'd1);
    check("ready_after_start", 32'(in_ready), 32'd1);
    send_byte(cnt[15:8], gap);
    send_byte(cnt[7:0], gap);
    if (cnt == 16'd0 || int'(cnt) > MAXW) begin
      check("hdr_done", 32'(done), 32'd1);
      check("hdr_error", 32'(error), (int'(cnt) > MAXW) ? 32'd1 : 32'd0);
      check("hdr_words", 32'(words_loaded), 32'd0);
      check("hdr_busy", 32'(busy), 32'd0);
      tick();
      check("hdr_ready", 32'(in_ready), 32'd0);
      return;
    end
    for (int i = 0; i < int'(cnt); i++) begin
      w = (words.size() > 0) ? words.pop_front() : $urandom();
      for (int k = 0; k < 4; k++) begin
        g = rand_gap ? int'($urandom_range(0, 2)) : gap;
        if (start_glitch && i == 0 && k == 0) begin
          start = 1'b1;
          tick();
          start = 1'b0;
        end
        b = w[31 - 8*k -: 8];
        send_byte(b, g);
        x = x ^ b;
      end
      exp_q.push_back({BASE + 32'(i) * 32'd4, w});
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_err = bad_csum;
    send_byte(bad_csum ? (x ^ 8'h01) : x, gap);
`else
    exp_err = 1'b0;
    if (bad_csum) x = 8'd0;
`endif
    tick();
    check("end_done", 32'(done), 32'd1);
    check("end_error", 32'(error), 32'(exp_err));
    check("end_busy", 32'(busy), 32'd0);
    check("end_hold", 32'(cpu_hold), 32'd0);
    check("end_ready", 32'(in_ready), 32'd0);
    check("end_words", 32'(words_loaded), 32'(cnt));
    check("end_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected completion within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    reset = 1'b1;
    tick();
    tick();
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", mem_addr, BASE);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_flags", {28'd0, cpu_hold, busy, done, error}, 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    reset = 1'b0;
    tick();

    // Two-word program, in_valid held high
    words = '{32'h2408_0005, 32'h8C09_0004};
    run_session(16'd2, 0, 1'b0, 1'b0, 1'b0);

    // Same program, valid toggling, stray start while busy
    words = '{32'h2408_0005, 32'h8C09_0004};
    run_session(16'd2, 1, 1'b0, 1'b1, 1'b0);

    // Header boundaries: oversize, zero, maximum
    run_session(16'h0101, 0, 1'b0, 1'b0, 1'b0);
    run_session(16'h0000, 0, 1'b0, 1'b0, 1'b0);
    run_session(16'hFFFF, 1, 1'b0, 1'b0, 1'b0);
    run_session(16'(MAXW), 0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of the second word
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    words = '{32'hA1B2_C3D4};
    for (int k = 0; k < 4; k++) send_byte(words[0][31 - 8*k -: 8], 0);
    exp_q.push_back({BASE, words.pop_front()});
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_hold", 32'(cpu_hold), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd0);
    check("midrst_words", 32'(words_loaded), 32'd0);
    check("midrst_pending", 32'(exp_q.size()), 32'd0);

    // Randomized sessions with random byte gaps
    for (int s = 0; s < 8; s++) begin
      run_session(16'($urandom_range(1, 6)), 0, 1'b1, 1'b0, 1'b0);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    words = '{32'h1122_3344};
    run_session(16'd1, 0, 1'b0, 1'b0, 1'b0);
    words = '{32'h1122_3344};
    run_session(16'd1, 0, 1'b0, 1'b0, 1'b1);
    for (int s = 0; s < 3; s++) begin
      run_session(16'($urandom_range(1, 4)), 0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
    end
`endif

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
